// File: rtl/mandelbrot_iter_ctrl_if.sv
// Bundles the point request, ALU and result handshakes of mandelbrot_iter_ctrl.
// The master modport is the controller side; the slave modport is its environment.
interface mandelbrot_iter_ctrl_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ITER_WIDTH = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_cr;
  logic [WIDTH-1:0]      in_ci;
  logic [ITER_WIDTH-1:0] max_iter;

  logic [WIDTH-1:0]      alu_cr;
  logic [WIDTH-1:0]      alu_ci;
  logic [WIDTH-1:0]      alu_zr;
  logic [WIDTH-1:0]      alu_zi;
  logic [WIDTH-1:0]      alu_out_zr;
  logic [WIDTH-1:0]      alu_out_zi;
  logic                  alu_size;
  logic                  alu_overflow;

  logic                  out_valid;
  logic                  out_ready;
  logic [ITER_WIDTH-1:0] out_iter;
  logic                  out_escaped;

  modport master (
    input  in_valid, in_cr, in_ci, max_iter,
    input  alu_out_zr, alu_out_zi, alu_size, alu_overflow,
    input  out_ready,
    output in_ready,
    output alu_cr, alu_ci, alu_zr, alu_zi,
    output out_valid, out_iter, out_escaped
  );

  modport slave (
    output in_valid, in_cr, in_ci, max_iter,
    output alu_out_zr, alu_out_zi, alu_size, alu_overflow,
    output out_ready,
    input  in_ready,
    input  alu_cr, alu_ci, alu_zr, alu_zi,
    input  out_valid, out_iter, out_escaped
  );
endinterface

// File: rtl/mandelbrot_iter_ctrl.sv
// Iteration sequencer for the combinational Mandelbrot ALU: holds c and z, counts
// iterations, stops on escape or limit. Optional abort input via MANDELBROT_ITER_ABORT_EN.
module mandelbrot_iter_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ITER_WIDTH = 6
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MANDELBROT_ITER_ABORT_EN
  input  logic abort,
`endif
  mandelbrot_iter_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state, w_state_nxt;
  logic [WIDTH-1:0]      r_cr, r_ci, r_zr, r_zi;
  logic [WIDTH-1:0]      w_cr_nxt, w_ci_nxt, w_zr_nxt, w_zi_nxt;
  logic [ITER_WIDTH-1:0] r_iter, r_lim, r_out_iter;
  logic [ITER_WIDTH-1:0] w_iter_nxt, w_lim_nxt, w_out_iter_nxt;
  logic                  r_out_escaped, w_out_escaped_nxt;
  logic                  r_out_valid, r_in_ready;
  logic                  w_abort;

`ifdef MANDELBROT_ITER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cr          <= '0;
      r_ci          <= '0;
      r_zr          <= '0;
      r_zi          <= '0;
      r_iter        <= '0;
      r_lim         <= '0;
      r_out_iter    <= '0;
      r_out_escaped <= 1'b0;
      r_out_valid   <= 1'b0;
      r_in_ready    <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_cr          <= w_cr_nxt;
      r_ci          <= w_ci_nxt;
      r_zr          <= w_zr_nxt;
      r_zi          <= w_zi_nxt;
      r_iter        <= w_iter_nxt;
      r_lim         <= w_lim_nxt;
      r_out_iter    <= w_out_iter_nxt;
      r_out_escaped <= w_out_escaped_nxt;
      r_out_valid   <= (w_state_nxt == S_DONE);
      r_in_ready    <= (w_state_nxt == S_IDLE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt       = r_state;
    w_cr_nxt          = r_cr;
    w_ci_nxt          = r_ci;
    w_zr_nxt          = r_zr;
    w_zi_nxt          = r_zi;
    w_iter_nxt        = r_iter;
    w_lim_nxt         = r_lim;
    w_out_iter_nxt    = r_out_iter;
    w_out_escaped_nxt = r_out_escaped;

    case (r_state)
      S_IDLE: begin
        // A concurrent abort suppresses the accept
        if (bus.in_valid && r_in_ready && !w_abort) begin
          w_cr_nxt    = bus.in_cr;
          w_ci_nxt    = bus.in_ci;
          w_lim_nxt   = bus.max_iter;
          w_zr_nxt    = '0;
          w_zi_nxt    = '0;
          w_iter_nxt  = '0;
          w_state_nxt = S_ITER;
        end
      end
      S_ITER: begin
        if (w_abort) begin
          w_zr_nxt    = '0;
          w_zi_nxt    = '0;
          w_iter_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else if (bus.alu_size || bus.alu_overflow) begin
          w_out_escaped_nxt = 1'b1;
          w_out_iter_nxt    = r_iter;
          w_state_nxt       = S_DONE;
        end else if (r_iter == r_lim) begin
          w_out_escaped_nxt = 1'b0;
          w_out_iter_nxt    = r_lim;
          w_state_nxt       = S_DONE;
        end else begin
          w_zr_nxt   = bus.alu_out_zr;
          w_zi_nxt   = bus.alu_out_zi;
          w_iter_nxt = r_iter + ITER_WIDTH'(1);
        end
      end
      S_DONE: begin
        if (w_abort) begin
          w_zr_nxt    = '0;
          w_zi_nxt    = '0;
          w_iter_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.alu_cr      = r_cr;
  assign bus.alu_ci      = r_ci;
  assign bus.alu_zr      = r_zr;
  assign bus.alu_zi      = r_zi;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_iter    = r_out_iter;
  assign bus.out_escaped = r_out_escaped;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Self-checking bench for mandelbrot_iter_ctrl: a behavioural Q2.6 ALU drives the
// datapath and a per-point escape-time model supplies the expected results.
module tb_mandelbrot_iter_ctrl;

  logic clk;
  logic rst_n;
`ifdef MANDELBROT_ITER_ABORT_EN
  logic abort;
`endif
  int total;
  int bad;

  mandelbrot_iter_ctrl_if #(.WIDTH(8), .ITER_WIDTH(6)) bus ();

  mandelbrot_iter_ctrl #(.WIDTH(8), .ITER_WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MANDELBROT_ITER_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One Mandelbrot step in Q2.6: z' = z^2 + c, flags on |z|^2 > 4 and out-of-range z'
  function automatic void alu_eval(input int cr, input int ci, input int zr, input int zi,
                                   output int nzr, output int nzi, output bit sz, output bit ov);
    int zr2;
    int zi2;
    int zrzi;
    zr2  = zr * zr;
    zi2  = zi * zi;
    zrzi = zr * zi;
    sz   = (zr2 + zi2) > 16384;
    nzr  = ((zr2 - zi2) >>> 6) + cr;
    nzi  = ((2 * zrzi) >>> 6) + ci;
    ov   = (nzr > 127) || (nzr < -128) || (nzi > 127) || (nzi < -128);
  endfunction

  int a_nzr, a_nzi;
  bit a_sz, a_ov;
  always_comb begin
    a_nzr = 0; a_nzi = 0; a_sz = 1'b0; a_ov = 1'b0;
    alu_eval($signed(bus.alu_cr), $signed(bus.alu_ci), $signed(bus.alu_zr), $signed(bus.alu_zi),
             a_nzr, a_nzi, a_sz, a_ov);
    bus.alu_out_zr   = 8'(a_nzr);
    bus.alu_out_zi   = 8'(a_nzi);
    bus.alu_size     = a_sz;
    bus.alu_overflow = a_ov;
  end

  // Escape-time reference: iteration index at which the point stops, and why
  function automatic void model(input int cr, input int ci, input int lim,
                                output int it, output bit esc);
    int zr, zi, nzr, nzi;
    bit sz, ov;
    zr = 0; zi = 0; it = 0; esc = 1'b0;
    for (int k = 0; k <= lim; k++) begin
      alu_eval(cr, ci, zr, zi, nzr, nzi, sz, ov);
      if (sz || ov) begin it = k; esc = 1'b1; return; end
      if (k == lim) begin it = lim; esc = 1'b0; return; end
      zr = nzr; zi = nzi;
    end
  endfunction

  // Presents a point at a negedge, then waits for out_valid; cyc is the latency in cycles
  task automatic start_and_wait(input int cr, input int ci, input int lim,
                                output int cyc, output bit to,
                                output logic [7:0] fcr, output logic [7:0] fci, output logic frdy);
    bus.in_cr    = 8'(cr);
    bus.in_ci    = 8'(ci);
    bus.max_iter = 6'(lim);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_cr    = 8'($urandom);
    bus.in_ci    = 8'($urandom);
    bus.max_iter = 6'($urandom);
    fcr  = bus.alu_cr;
    fci  = bus.alu_ci;
    frdy = bus.in_ready;
    cyc  = 1;
    to   = 1'b0;
    while (bus.out_valid !== 1'b1) begin
      if (cyc >= 120) begin to = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_out(input int hold);
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // Runs one point end to end and compares everything observable against the model
  task automatic check_point(input string name, input int cr, input int ci, input int lim,
                             input int hold);
    int cyc, eit;
    bit to, eesc;
    logic [7:0] fcr, fci;
    logic frdy;
    model(cr, ci, lim, eit, eesc);
    start_and_wait(cr, ci, lim, cyc, to, fcr, fci, frdy);
    total++;
    if (to) begin bad++; $display("FAIL %s timeout: out_valid never rose", name); end
    total++;
    if (bus.out_iter !== 6'(eit)) begin
      bad++; $display("FAIL %s out_iter: got %0d want %0d", name, bus.out_iter, eit);
    end
    total++;
    if (bus.out_escaped !== eesc) begin
      bad++; $display("FAIL %s out_escaped: got %b want %b", name, bus.out_escaped, eesc);
    end
    total++;
    if (cyc != eit + 2) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, eit + 2);
    end
    total++;
    if (fcr !== 8'(cr) || fci !== 8'(ci) || frdy !== 1'b0) begin
      bad++; $display("FAIL %s first ITER: cr=%0h ci=%0h rdy=%b want cr=%0h ci=%0h rdy=0",
                      name, fcr, fci, frdy, 8'(cr), 8'(ci));
    end
    release_out(hold);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1",
                      name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset handshake: out_valid=%b in_ready=%b want 0/1",
                      bus.out_valid, bus.in_ready);
    end
    total++;
    if (bus.out_iter !== 6'd0 || bus.out_escaped !== 1'b0) begin
      bad++; $display("FAIL reset result: out_iter=%0d escaped=%b want 0/0",
                      bus.out_iter, bus.out_escaped);
    end
    total++;
    if ({bus.alu_cr, bus.alu_ci, bus.alu_zr, bus.alu_zi} !== 32'd0) begin
      bad++; $display("FAIL reset alu regs: got %h want 0",
                      {bus.alu_cr, bus.alu_ci, bus.alu_zr, bus.alu_zi});
    end
  endtask

  task automatic test_directed();
    check_point("origin", 0, 0, 20, 0);
    total++;
    if (bus.out_iter !== 6'd20) begin
      bad++; $display("FAIL origin const: out_iter=%0d want 20", bus.out_iter);
    end
    check_point("fast_escape", 127, 0, 20, 1);
    total++;
    if (bus.out_iter !== 6'd1 || bus.out_escaped !== 1'b1) begin
      bad++; $display("FAIL fast_escape const: iter=%0d esc=%b want 1/1",
                      bus.out_iter, bus.out_escaped);
    end
    check_point("bounded_orbit", -64, 0, 15, 0);
    check_point("edge_limit", 0, 0, 0, 0);
    check_point("max_limit", -16, 8, 63, 2);
  endtask

  task automatic test_backpressure();
    int cyc, eit;
    bit to, eesc;
    logic [7:0] fcr, fci;
    logic frdy;
    model(-64, 0, 5, eit, eesc);
    start_and_wait(-64, 0, 5, cyc, to, fcr, fci, frdy);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_cr    = 8'($urandom);
      bus.max_iter = 6'($urandom);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_iter !== 6'(eit) || bus.out_escaped !== eesc) begin
        bad++; $display("FAIL backpressure hold %0d: valid=%b rdy=%b iter=%0d esc=%b want 1/0/%0d/%b",
                        i, bus.out_valid, bus.in_ready, bus.out_iter, bus.out_escaped, eit, eesc);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL backpressure release: valid=%b rdy=%b want 0/1",
                      bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL backpressure idle: rdy=%b valid=%b want 1/0",
                      bus.in_ready, bus.out_valid);
    end
  endtask

  // Starts a long-running point and leaves it at iter=7
  task automatic start_to_iter7();
    bus.in_cr = 8'(-64); bus.in_ci = 8'd0; bus.max_iter = 6'd30; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic test_reset_mid_iter();
    start_to_iter7();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || {bus.alu_cr, bus.alu_zr} !== 16'd0) begin
      bad++; $display("FAIL mid_reset clear: valid=%b cr=%0h zr=%0h want 0/0/0",
                      bus.out_valid, bus.alu_cr, bus.alu_zr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset idle: rdy=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    check_point("after_reset", 20, -30, 25, 0);
  endtask

`ifdef MANDELBROT_ITER_ABORT_EN
  task automatic test_abort();
    int cyc;
    bit to;
    logic [7:0] fcr, fci;
    logic frdy;
    start_to_iter7();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.alu_zr !== 8'd0) begin
      bad++; $display("FAIL abort iter: valid=%b rdy=%b zr=%0h want 0/1/0",
                      bus.out_valid, bus.in_ready, bus.alu_zr);
    end
    start_and_wait(0, 0, 3, cyc, to, fcr, fci, frdy);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL abort done: valid=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    check_point("after_abort", -40, 24, 12, 0);
  endtask
`endif

  task automatic test_random();
    int cr, ci, lim;
    for (int n = 0; n < 40; n++) begin
      if (n[0]) begin
        cr = $urandom_range(0, 255) - 128;
        ci = $urandom_range(0, 255) - 128;
      end else begin
        cr = $urandom_range(0, 60) - 45;
        ci = $urandom_range(0, 60) - 30;
      end
      lim = $urandom_range(0, 63);
      check_point($sformatf("rand%0d", n), cr, ci, lim, $urandom_range(0, 3));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
`ifdef MANDELBROT_ITER_ABORT_EN
    abort = 1'b0;
`endif
    bus.in_valid  = 1'b0;
    bus.in_cr     = '0;
    bus.in_ci     = '0;
    bus.max_iter  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_iter();
`ifdef MANDELBROT_ITER_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mandelbrot_iter_ctrl.md
Name: mandelbrot_iter_ctrl

Overview:
Sequencing stage directly upstream of the combinational Mandelbrot ALU.
- Accepts one point c = (cr, ci) per transaction and holds z in registers.
- Feeds c and z to the ALU each cycle and writes the ALU's next z back into the registers.
- Stops on escape (|z|^2 > 4 or ALU overflow) or when the iteration limit is reached.
- Returns the iteration count to the downstream pixel/colour stage over a valid/ready handshake.

Parameters:
WIDTH, 8, fixed-point width of cr/ci/zr/zi; format 2.(WIDTH-2) signed, so 1.0 = 1<<(WIDTH-2).
ITER_WIDTH, 6, width of the iteration counter and of max_iter.

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  point request valid
in_ready  output  1  block can accept a point
in_cr  input  WIDTH  real part of c, signed
in_ci  input  WIDTH  imaginary part of c, signed
max_iter  input  ITER_WIDTH  iteration limit, sampled at accept
alu_cr  output  WIDTH  latched cr to ALU
alu_ci  output  WIDTH  latched ci to ALU
alu_zr  output  WIDTH  current zr to ALU
alu_zi  output  WIDTH  current zi to ALU
alu_out_zr  input  WIDTH  next zr from ALU
alu_out_zi  input  WIDTH  next zi from ALU
alu_size  input  1  ALU flag: |z|^2 > 4 for current z
alu_overflow  input  1  ALU flag: next z not representable
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_iter  output  ITER_WIDTH  iteration count at termination
out_escaped  output  1  1 = point escaped, 0 = limit reached

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cr, ci, zr, zi, iter, lim, out_iter, out_escaped all cleared to 0; out_valid=0; in_ready=1 once rst_n deasserts.
- ALU outputs alu_cr/alu_ci/alu_zr/alu_zi come directly from registers (no combinational path from inputs).
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch cr, ci and lim=max_iter; zr=zi=0; iter=0; go to ITER.
- ITER (one ALU evaluation per cycle, in_ready=0):
  - if alu_size | alu_overflow: out_escaped<=1, out_iter<=iter, go to DONE.
  - else if iter == lim: out_escaped<=0, out_iter<=lim, go to DONE.
  - else: zr<=alu_out_zr, zi<=alu_out_zi, iter<=iter+1, stay in ITER.
  - Escape takes priority over the limit check when both occur in the same cycle.
  - iter never wraps, because it stops at lim ≤ 2^ITER_WIDTH-1.
- DONE:
  - out_valid=1; out_iter and out_escaped are held stable while out_ready=0.
  - On out_ready: out_valid<=0 and go to IDLE.
  - in_ready=0 in DONE, so no overlap between transactions.
- Latency: accept at cycle T; first ITER at T+1; out_valid at T+N+2, where N = number of ITER cycles minus 1.
  - Non-escaping point: N = lim, so out_valid at T+lim+2.
  - max_iter=0: exactly one ITER cycle, then out_iter=0; out_escaped=0 unless the ALU flags fire on z=0.
- in_valid is ignored outside IDLE. in_cr/in_ci/max_iter are sampled only at accept.
- Reset mid-ITER or mid-DONE: immediate return to IDLE with all registers cleared; the result is lost.

Optional Feature:
MANDELBROT_ITER_ABORT_EN:
- Defined: adds input port abort (1 bit). abort=1 in ITER or DONE forces IDLE on the next edge; out_valid<=0; zr, zi, iter cleared; no result is produced. abort in IDLE has no effect and has priority over in_valid.
- Undefined: the port is absent and the FSM has no abort path.

Test Plan:
- Origin: WIDTH=8, c=(0,0), max_iter=20 -> out_escaped=0, out_iter=20; out_valid exactly 22 cycles after accept.
- Fast escape: c=(127,0) (≈1.98), max_iter=20 -> overflow on the second ITER; out_escaped=1, out_iter=1.
- Bounded orbit: c=(-64,0) (-1.0), max_iter=15; z alternates 0, -1 -> out_escaped=0, out_iter=15.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_iter/out_escaped stable, in_ready=0 and in_valid ignored; on out_ready=1, IDLE and in_ready=1 next cycle.
- Edge limit: max_iter=0, c=(0,0) -> one ITER cycle; out_iter=0, out_escaped=0.
- Reset: assert rst_n=0 during ITER at iter=7 -> out_valid=0, in_ready=1 after release, next point processes correctly. With the macro defined, repeat using abort=1 -> same result.
